// File: rtl/mult_n_seq.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle, LSB first,
// with optional two's-complement operands handled by sign-magnitude conversion.
module mult_n_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   pp,
    output logic                 done,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    pp_q, pp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    acc_sum;

    always_comb begin
        // Negating the most negative value wraps to 2^(WIDTH-1), which is the
        // correct magnitude when read back as unsigned.
        mag_a   = (signed_mode && A[WIDTH-1]) ? -A : A;
        mag_b   = (signed_mode && B[WIDTH-1]) ? -B : B;
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        pp_d     = pp_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;

        case (state_q)
            IDLE, DONE: begin
                if (init) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    sign_d   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CNT_LOAD;
                    state_d  = CALC;
                end else begin
                    state_d  = IDLE;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    pp_d    = sign_q ? -acc_sum : acc_sum;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            pp_q     <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            pp_q     <= pp_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
        end
    end

    assign pp   = pp_q;
    assign done = (state_q == DONE);
    assign busy = (state_q == CALC);

endmodule

// File: doc/mult_n_seq.md
MULT_N_SEQ -- requirements
Module: mult_n_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: init  input  1  start request, sampled at the rising edge.
REQ-005 Port: signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands.
REQ-006 Port: A  input  WIDTH  multiplicand.
REQ-007 Port: B  input  WIDTH  multiplier.
REQ-008 Port: pp  output  2*WIDTH  product register.
REQ-009 Port: done  output  1  single-cycle result-valid pulse.
REQ-010 Port: busy  output  1  high while a multiply is in progress.

Function
REQ-011 The FSM SHALL have three states, IDLE, CALC and DONE, all registered.
REQ-012 In IDLE or DONE, init=1 SHALL capture A, B and signed_mode internally, load the bit counter with WIDTH, clear the accumulator and enter CALC; this edge is the accept edge.
REQ-013 In CALC, init SHALL be ignored, and A, B and signed_mode changes SHALL NOT affect the result in progress.
REQ-014 When signed_mode=1 at capture, both operands SHALL be converted to WIDTH-bit unsigned magnitudes, so the most negative value maps to 2^(WIDTH-1) without overflow, and the sign flag SHALL be set to A[msb] XOR B[msb].
REQ-015 When signed_mode=0, operands SHALL be used unchanged and the sign flag SHALL be cleared.
REQ-016 Each CALC cycle SHALL process one multiplier bit, LSB first: if the bit is 1, add the shifted multiplicand to the 2*WIDTH accumulator; shift the multiplicand left and the multiplier right; decrement the counter.
REQ-017 CALC SHALL last exactly WIDTH cycles regardless of operand values (no early termination).
REQ-018 On the edge that processes the last bit, the FSM SHALL enter DONE and load pp with the final product.
REQ-019 The final product SHALL be the accumulator, or its two's-complement negation when the sign flag is set.
REQ-020 done SHALL be 1 only in the DONE state, i.e. for exactly one cycle, visible WIDTH edges after the accept edge.
REQ-021 From DONE, the FSM SHALL go to CALC if init=1, else to IDLE.
REQ-022 With init held high, results SHALL therefore complete every WIDTH+1 cycles.
REQ-023 busy SHALL be 1 in CALC and 0 in IDLE and DONE.
REQ-024 pp SHALL change only on entry to DONE or on reset, and SHALL hold its value otherwise, including through subsequent CALC phases.
REQ-025 A zero operand SHALL still take the full WIDTH cycles and yield pp=0.
REQ-026 Product width SHALL be 2*WIDTH and SHALL never overflow in either mode.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE and clear pp, done, busy, the accumulator, the counter, the captured operands and the sign flag.
REQ-028 rst SHALL take priority over init in every state; asserting rst mid-CALC SHALL abort the operation with no done pulse and pp=0.
REQ-029 On the first edge with rst=0, the block SHALL be in IDLE and able to accept init.

Verification (WIDTH=4 unless stated)
REQ-030 Unsigned max: A=15, B=15, signed_mode=0, 1-cycle init -> busy high 4 cycles; done pulses once, 4 edges after accept; pp=0xE1.
REQ-031 Signed corners: A=-8, B=-8 -> pp=0x40; A=-3, B=5 -> pp=0xF1; A=7, B=-1 -> pp=0xF9.
REQ-032 Init and operand changes during CALC: pulse init with new A/B 2 cycles after accept -> ignored; first result is unchanged; exactly one done pulse.
REQ-033 Back-to-back operation: init held high with A=3,B=3 then A=2,B=5 -> done every 5 cycles; pp=0x09 then pp=0x0A; pp is stable between done pulses.
REQ-034 Reset mid-operation: rst=1 in the 3rd CALC cycle -> next cycle IDLE, pp=0, done=0, busy=0; a following A=1,B=1 init -> pp=0x01.
REQ-035 Reconfigured at WIDTH=8: A=-128, B=-128, signed_mode=1 -> done 8 edges after accept, pp=0x4000; A=255, B=255, signed_mode=0 -> pp=0xFE01.
